// File: rtl/md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: md_op encodings,
// the HI/LO pair type and the combinational result function.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'h0,
    MD_MULT  = 4'h1,
    MD_MULTU = 4'h2,
    MD_DIV   = 4'h3,
    MD_DIVU  = 4'h4,
    MD_MTHI  = 4'h5,
    MD_MTLO  = 4'h6,
    MD_MFHI  = 4'h7,
    MD_MFLO  = 4'h8
  } md_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Result of a mult/div op; a divide by zero (or any other op) returns cur so
  // the later commit leaves HI/LO unchanged.
  function automatic hilo_t md_result(input logic [3:0]  op,
                                      input logic [31:0] rs,
                                      input logic [31:0] rt,
                                      input hilo_t       cur);
    hilo_t       r;
    logic [63:0] prod;
    logic [31:0] d;
    r    = cur;
    prod = '0;
    d    = (rt == 32'd0) ? 32'd1 : rt;
    case (op)
      MD_MULT: begin
        // The low 64 bits of a product of sign-extended operands equal the signed product.
        prod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        r    = prod;
      end
      MD_MULTU: begin
        prod = {32'd0, rs} * {32'd0, rt};
        r    = prod;
      end
      MD_DIV: begin
        if (rt != 32'd0) begin
          if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
            r.lo = 32'h8000_0000;
            r.hi = 32'd0;
          end else begin
            r.lo = $signed(rs) / $signed(d);
            r.hi = $signed(rs) % $signed(d);
          end
        end
      end
      MD_DIVU: begin
        if (rt != 32'd0) begin
          r.lo = rs / d;
          r.hi = rs % d;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Results are computed at start and
// committed after a fixed latency that only models the iterative hardware timing.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);
  import md_unit_pkg::*;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0] cnt;
  hilo_t      pend;
  hilo_t      res;
  logic       is_mul;
  logic       is_div;
  logic       is_mt;

  assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign is_mt  = (md_op == MD_MTHI) || (md_op == MD_MTLO);
  assign start  = (is_mul || is_div) && !busy;
  assign res    = md_result(md_op, rs_data, rt_data, {hi, lo});

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    mf_data = 32'd0;
    case (md_op)
      MD_MFHI: mf_data = hi;
      MD_MFLO: mf_data = lo;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      pend <= '0;
      cnt  <= 4'd0;
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt == 4'd1) begin
        hi   <= pend.hi;
        lo   <= pend.lo;
        cnt  <= 4'd0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (start) begin
      pend <= res;
      cnt  <= is_mul ? MULT_CNT : DIV_CNT;
      busy <= 1'b1;
    end else if (md_op == MD_MTHI) begin
      hi <= rs_data;
    end else if (md_op == MD_MTLO) begin
      lo <= rs_data;
    end
  end

  // The hazard unit must never let a move-to reach EX while an op is in flight.
  always_ff @(posedge clk) begin
    if (!reset && busy) assert (!is_mt);
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table for single operations plus hand
// sequences for start-while-busy and mid-operation reset.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .start   (start),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_start;
    int          exp_cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vec [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops, bounded so a stuck busy still terminates.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int total;

    vec[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vec[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    vec[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vec[3]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vec[4]  = '{MD_MTHI,  32'h1234_5678, 32'h0000_0000, 1'b0, 0,  32'h1234_5678, 32'hFFFF_FFFD};
    vec[5]  = '{MD_MTLO,  32'hCAFE_BABE, 32'h0000_0000, 1'b0, 0,  32'h1234_5678, 32'hCAFE_BABE};
    vec[6]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h0000_0000, 32'h8000_0000};
    vec[7]  = '{MD_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 10, 32'h0000_0001, 32'h7FFF_FFFC};
    vec[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vec[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 5,  32'h4000_0000, 32'h0000_0000};
    vec[10] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 5,  32'h0000_0001, 32'h0000_0000};
    vec[11] = '{MD_DIV,   32'hFFFF_FFF8, 32'h0000_0003, 1'b1, 10, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    vec[12] = '{4'hF,     32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 0,  32'hFFFF_FFFE, 32'hFFFF_FFFE};

    reset   = 1'b1;
    md_op   = MD_NONE;
    rs_data = 32'd0;
    rt_data = 32'd0;
    step();
    step();
    reset = 1'b0;
    check("reset_hi",      hi,             32'd0);
    check("reset_lo",      lo,             32'd0);
    check("reset_busy",    {31'd0, busy},  32'd0);
    check("reset_start",   {31'd0, start}, 32'd0);
    check("reset_mf_data", mf_data,        32'd0);

    foreach (vec[i]) begin
      md_op   = vec[i].op;
      rs_data = vec[i].rs;
      rt_data = vec[i].rt;
      #1;
      check($sformatf("v%0d_start", i), {31'd0, start}, {31'd0, vec[i].exp_start});
      step();
      md_op = MD_NONE;
      wait_idle(n);
      check($sformatf("v%0d_busy_cycles", i), n, vec[i].exp_cycles);
      check($sformatf("v%0d_hi", i), hi, vec[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vec[i].exp_lo);
      md_op = MD_MFHI;
      #1;
      check($sformatf("v%0d_mfhi", i), mf_data, vec[i].exp_hi);
      md_op = MD_MFLO;
      #1;
      check($sformatf("v%0d_mflo", i), mf_data, vec[i].exp_lo);
      md_op = MD_NONE;
      #1;
      check($sformatf("v%0d_mf_none", i), mf_data, 32'd0);
    end

    // Second MULT arrives in busy cycle 2: it must not start or disturb the first.
    md_op   = MD_MULT;
    rs_data = 32'd3;
    rt_data = 32'd4;
    step();
    md_op = MD_NONE;
    step();
    md_op   = MD_MULT;
    rs_data = 32'd100;
    rt_data = 32'd100;
    #1;
    check("overlap_start_blocked", {31'd0, start}, 32'd0);
    check("overlap_busy",          {31'd0, busy},  32'd1);
    step();
    md_op = MD_NONE;
    wait_idle(n);
    total = 2 + n;
    check("overlap_busy_cycles", total, 5);
    check("overlap_hi", hi, 32'd0);
    check("overlap_lo", lo, 32'd12);
    repeat (8) step();
    check("overlap_no_second_busy", {31'd0, busy}, 32'd0);
    check("overlap_lo_stable",      lo,            32'd12);

    // Reset during busy cycle 4 of a DIV aborts it; nothing commits afterwards.
    md_op   = MD_DIV;
    rs_data = 32'd100;
    rt_data = 32'd7;
    step();
    md_op = MD_NONE;
    repeat (3) step();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi",   hi,            32'd0);
    check("abort_lo",   lo,            32'd0);
    reset = 1'b0;
    repeat (15) step();
    check("abort_no_commit_hi",   hi,            32'd0);
    check("abort_no_commit_lo",   lo,            32'd0);
    check("abort_no_commit_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // The hazard unit never lets mfhi/mflo reach EX while busy; this bench honours that.
  always @(negedge clk) begin
    if (!reset && busy) assert (md_op != MD_MFHI && md_op != MD_MFLO);
  end

endmodule
